// File: rtl/errdet_pkg.sv
// Shared types and helpers for the multi-channel sliding-window error detector.
package errdet_pkg;

  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_WARN = 2'b01,
    ST_ERR  = 2'b10
  } errdet_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/errdet_channel.sv
// One channel: N-sample window, running error count and OK/WARN/ERR state.
// ERRDET_STICKY_EN makes ERR latch until clear or reset.
module errdet_channel
  import errdet_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 4,
  parameter int H = 8,
  localparam int CW = cnt_width(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in,
  input  logic          clear,
  output logic [CW-1:0] count,
  output errdet_state_t state
);

  localparam logic [CW-1:0] W_C = CW'(W);
  localparam logic [CW-1:0] H_C = CW'(H);

  logic [N-1:0]  window;
  logic [CW-1:0] count_next;
  errdet_state_t state_next;

  always_comb begin
    count_next = count + CW'(in) - CW'(window[N-1]);
    state_next = ST_OK;
    if (count_next >= H_C) begin
      state_next = ST_ERR;
    end else if (count_next >= W_C) begin
      state_next = ST_WARN;
    end
`ifdef ERRDET_STICKY_EN
    if (state == ST_ERR) begin
      state_next = ST_ERR;
    end
`endif
  end

  // clear wins over in_valid; the sample on that edge is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      window <= '0;
      count  <= '0;
      state  <= ST_OK;
    end else if (clear) begin
      window <= '0;
      count  <= '0;
      state  <= ST_OK;
    end else if (in_valid) begin
      window <= {window[N-2:0], in};
      count  <= count_next;
      state  <= state_next;
    end
  end

endmodule

// File: rtl/error_detector_mc.sv
// C-channel sliding-window bit-error detector with aggregate alarm and count readback.
// Build with ERRDET_STICKY_EN to make per-channel ERR latch until clear/reset.
module error_detector_mc
  import errdet_pkg::*;
#(
  parameter int C = 4,
  parameter int N = 64,
  parameter int W = 4,
  parameter int H = 8,
  localparam int CW = cnt_width(N),
  localparam int SW = (C > 1) ? $clog2(C) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [C-1:0]  in,
  input  logic [C-1:0]  clear,
  input  logic [SW-1:0] sel,
  output logic [C-1:0]  warning,
  output logic [C-1:0]  error,
  output logic          any_error,
  output logic [CW-1:0] count_out
);

  logic [CW-1:0] counts [C];
  errdet_state_t states [C];

  for (genvar c = 0; c < C; c++) begin : g_ch
    errdet_channel #(
      .N(N),
      .W(W),
      .H(H)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .in_valid (in_valid),
      .in       (in[c]),
      .clear    (clear[c]),
      .count    (counts[c]),
      .state    (states[c])
    );

    assign warning[c] = (states[c] != ST_OK);
    assign error[c]   = (states[c] == ST_ERR);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      any_error <= 1'b0;
    end else begin
      any_error <= |error;
    end
  end

  // Out-of-range selects (non-power-of-two C) read back as zero.
  always_comb begin
    count_out = '0;
    if (int'(sel) < C) begin
      count_out = counts[sel];
    end
  end

endmodule
